parking_slot_manager: RTL and testbench

- Parametrised multi-slot successor to the single-bay parking controller: token-checked entry and exit for SLOTS bays.
- Per-slot entry-time registers; on exit, computes the parked duration with modular arithmetic.
- Counts wrong-token attempts and locks the interface out after MAX_TRIES consecutive failures.
- Sits between the user keypad/token front end and the billing/display logic.

---
 rtl/parking_slot_manager.sv | 230 +++++++++++++++++++++++
 tb/tb_parking_slot_manager.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_slot_manager.sv
// Multi-bay parking controller: token-checked entry/exit, per-slot entry timestamps, lockout after repeated failures.
// Optional build macro CONFIRM_TIMEOUT_EN adds a confirm timeout in WAIT_CONFIRM.
module parking_slot_manager #(
  parameter int SLOTS       = 4,
  parameter int TOKEN_W     = 3,
  parameter int TIME_W      = 8,
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_CYCLES = 16,
  parameter int TIMEOUT     = 32,
  localparam int IDX_W      = (SLOTS > 1) ? $clog2(SLOTS) : 1,
  localparam int CNT_W      = $clog2(SLOTS + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [TOKEN_W-1:0] system_token,
  input  logic [TOKEN_W-1:0] user_token,
  input  logic               request,
  input  logic               exit_req,
  input  logic [IDX_W-1:0]   slot_id,
  input  logic               confirm,
  input  logic [TIME_W-1:0]  time_data,
  output logic               grant,
  output logic               deny,
  output logic               locked,
  output logic               busy,
  output logic [IDX_W-1:0]   alloc_slot,
  output logic [SLOTS-1:0]   occupied,
  output logic [CNT_W-1:0]   free_count,
  output logic [TIME_W-1:0]  entry_time_out,
  output logic [TIME_W-1:0]  duration_out
);

  localparam int FAIL_W = $clog2(MAX_TRIES + 1);
  localparam int LCK_W  = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_CONFIRM = 2'd1,
    LOCKOUT      = 2'd2
  } state_e;

  typedef enum logic {
    MODE_ENTRY = 1'b0,
    MODE_EXIT  = 1'b1
  } mode_e;

  state_e              state_q, state_d;
  mode_e               mode_q, mode_d;
  logic [IDX_W-1:0]    slot_q, slot_d;
  logic [FAIL_W-1:0]   fail_q, fail_d;
  logic [LCK_W-1:0]    lock_cnt_q, lock_cnt_d;
  logic                grant_q, grant_d;
  logic                deny_q, deny_d;
  logic [IDX_W-1:0]    alloc_slot_q, alloc_slot_d;
  logic [SLOTS-1:0]    occupied_q, occupied_d;
  logic [CNT_W-1:0]    free_count_q, free_count_d;
  logic [TIME_W-1:0]   entry_time_out_q, entry_time_out_d;
  logic [TIME_W-1:0]   duration_out_q, duration_out_d;
  logic [TIME_W-1:0]   entry_time_q [SLOTS];
  logic [TIME_W-1:0]   entry_time_d [SLOTS];

  logic [IDX_W-1:0]    free_idx;
  logic                slot_in_range;
  logic                token_match;

`ifdef CONFIRM_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
`else
  // TIMEOUT only matters when the confirm timeout is compiled in.
  logic                unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  assign slot_in_range = (32'(slot_id) < 32'(SLOTS));
  assign token_match   = (user_token == system_token);

  // Lowest-index free bay; only consulted when at least one bay is free.
  always_comb begin
    free_idx = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!occupied_q[i]) free_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_d          = state_q;
    mode_d           = mode_q;
    slot_d           = slot_q;
    fail_d           = fail_q;
    lock_cnt_d       = lock_cnt_q;
    grant_d          = 1'b0;
    deny_d           = 1'b0;
    alloc_slot_d     = alloc_slot_q;
    occupied_d       = occupied_q;
    free_count_d     = free_count_q;
    entry_time_out_d = entry_time_out_q;
    duration_out_d   = duration_out_q;
    entry_time_d     = entry_time_q;
`ifdef CONFIRM_TIMEOUT_EN
    to_cnt_d         = to_cnt_q;
`endif

    case (state_q)
      IDLE: begin
`ifdef CONFIRM_TIMEOUT_EN
        to_cnt_d = '0;
`endif
        if (exit_req) begin
          if (slot_in_range && occupied_q[slot_id]) begin
            state_d = WAIT_CONFIRM;
            mode_d  = MODE_EXIT;
            slot_d  = slot_id;
          end else begin
            deny_d = 1'b1;
          end
        end else if (request) begin
          if (free_count_q == '0) begin
            deny_d = 1'b1;
          end else begin
            state_d = WAIT_CONFIRM;
            mode_d  = MODE_ENTRY;
          end
        end
      end

      WAIT_CONFIRM: begin
        if (confirm) begin
          state_d = IDLE;
          if (token_match) begin
            grant_d = 1'b1;
            fail_d  = '0;
            if (mode_q == MODE_ENTRY) begin
              alloc_slot_d           = free_idx;
              entry_time_d[free_idx] = time_data;
              occupied_d[free_idx]   = 1'b1;
              free_count_d           = free_count_q - CNT_W'(1);
              entry_time_out_d       = time_data;
              duration_out_d         = '0;
            end else begin
              // Modular subtraction handles a clock wrap between entry and exit.
              alloc_slot_d         = slot_q;
              entry_time_out_d     = entry_time_q[slot_q];
              duration_out_d       = time_data - entry_time_q[slot_q];
              occupied_d[slot_q]   = 1'b0;
              free_count_d         = free_count_q + CNT_W'(1);
            end
          end else begin
            deny_d = 1'b1;
            if (fail_q == FAIL_W'(MAX_TRIES - 1)) begin
              state_d    = LOCKOUT;
              fail_d     = '0;
              lock_cnt_d = '0;
            end else begin
              fail_d = fail_q + FAIL_W'(1);
            end
          end
`ifdef CONFIRM_TIMEOUT_EN
        end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          deny_d  = 1'b1;
          state_d = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
`else
        end
`endif
      end

      LOCKOUT: begin
        if (lock_cnt_q == LCK_W'(LOCK_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          lock_cnt_d = lock_cnt_q + LCK_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q          <= IDLE;
      mode_q           <= MODE_ENTRY;
      slot_q           <= '0;
      fail_q           <= '0;
      lock_cnt_q       <= '0;
      grant_q          <= 1'b0;
      deny_q           <= 1'b0;
      alloc_slot_q     <= '0;
      occupied_q       <= '0;
      free_count_q     <= CNT_W'(SLOTS);
      entry_time_out_q <= '0;
      duration_out_q   <= '0;
      for (int i = 0; i < SLOTS; i++) entry_time_q[i] <= '0;
`ifdef CONFIRM_TIMEOUT_EN
      to_cnt_q         <= '0;
`endif
    end else begin
      state_q          <= state_d;
      mode_q           <= mode_d;
      slot_q           <= slot_d;
      fail_q           <= fail_d;
      lock_cnt_q       <= lock_cnt_d;
      grant_q          <= grant_d;
      deny_q           <= deny_d;
      alloc_slot_q     <= alloc_slot_d;
      occupied_q       <= occupied_d;
      free_count_q     <= free_count_d;
      entry_time_out_q <= entry_time_out_d;
      duration_out_q   <= duration_out_d;
      for (int i = 0; i < SLOTS; i++) entry_time_q[i] <= entry_time_d[i];
`ifdef CONFIRM_TIMEOUT_EN
      to_cnt_q         <= to_cnt_d;
`endif
    end
  end

  assign grant          = grant_q;
  assign deny           = deny_q;
  assign locked         = (state_q == LOCKOUT);
  assign busy           = (state_q != IDLE);
  assign alloc_slot     = alloc_slot_q;
  assign occupied       = occupied_q;
  assign free_count     = free_count_q;
  assign entry_time_out = entry_time_out_q;
  assign duration_out   = duration_out_q;

endmodule

// File: tb/tb_parking_slot_manager.sv
// Scoreboard bench for parking_slot_manager: a transaction-level bay model predicts every grant/deny,
// and an independent monitor compares each pulse the DUT presents against the queued prediction.
module tb_parking_slot_manager;

  localparam int SLOTS       = 4;
  localparam int TOKEN_W     = 3;
  localparam int TIME_W      = 8;
  localparam int MAX_TRIES   = 3;
  localparam int LOCK_CYCLES = 16;
  localparam int TIMEOUT     = 32;
  localparam int IDX_W       = 2;
  localparam int CNT_W       = 3;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic [TOKEN_W-1:0] system_token = '0;
  logic [TOKEN_W-1:0] user_token = '0;
  logic               request = 1'b0;
  logic               exit_req = 1'b0;
  logic [IDX_W-1:0]   slot_id = '0;
  logic               confirm = 1'b0;
  logic [TIME_W-1:0]  time_data = '0;
  logic               grant, deny, locked, busy;
  logic [IDX_W-1:0]   alloc_slot;
  logic [SLOTS-1:0]   occupied;
  logic [CNT_W-1:0]   free_count;
  logic [TIME_W-1:0]  entry_time_out, duration_out;

  always #5 clock = ~clock;

  parking_slot_manager #(
    .SLOTS(SLOTS), .TOKEN_W(TOKEN_W), .TIME_W(TIME_W),
    .MAX_TRIES(MAX_TRIES), .LOCK_CYCLES(LOCK_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .reset(reset), .system_token(system_token), .user_token(user_token),
    .request(request), .exit_req(exit_req), .slot_id(slot_id), .confirm(confirm),
    .time_data(time_data), .grant(grant), .deny(deny), .locked(locked), .busy(busy),
    .alloc_slot(alloc_slot), .occupied(occupied), .free_count(free_count),
    .entry_time_out(entry_time_out), .duration_out(duration_out)
  );

  typedef struct {
    bit isGrant;
    int slot;
    int entryTime;
    int duration;
    int occWord;
    int freeSlots;
  } exp_t;

  exp_t expQ[$];
  int   checkCount = 0;
  int   passCount = 0;

  // Bay model: which bays hold a car, when it arrived, consecutive token failures, last granted result.
  bit   occModel[SLOTS];
  int   entryModel[SLOTS];
  int   failModel;
  int   lastSlot, lastEntry, lastDuration;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int modelOccWord();
    int w = 0;
    for (int i = 0; i < SLOTS; i++) if (occModel[i]) w += (1 << i);
    return w;
  endfunction

  function automatic int modelFree();
    int n = SLOTS;
    for (int i = 0; i < SLOTS; i++) if (occModel[i]) n--;
    return n;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < SLOTS; i++) begin
      occModel[i] = 1'b0;
      entryModel[i] = 0;
    end
    failModel = 0;
    lastSlot = 0;
    lastEntry = 0;
    lastDuration = 0;
  endtask

  task automatic pushResult(input bit isGrant);
    exp_t e;
    e.isGrant = isGrant;
    e.slot = lastSlot;
    e.entryTime = lastEntry;
    e.duration = lastDuration;
    e.occWord = modelOccWord();
    e.freeSlots = modelFree();
    expQ.push_back(e);
  endtask

  // Monitor: every grant/deny pulse must match the oldest prediction.
  always @(negedge clock) begin
    exp_t e;
    if (reset && (grant || deny)) begin
      checkOutput("grant_deny_exclusive", int'(grant && deny), 0);
      if (expQ.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL unexpected_pulse: got grant=%0b deny=%0b, expected no pulse (t=%0t)",
                 grant, deny, $time);
      end else begin
        e = expQ.pop_front();
        checkOutput("grant", int'(grant), int'(e.isGrant));
        checkOutput("alloc_slot", int'(alloc_slot), e.slot);
        checkOutput("entry_time_out", int'(entry_time_out), e.entryTime);
        checkOutput("duration_out", int'(duration_out), e.duration);
        checkOutput("occupied", int'(occupied), e.occWord);
        checkOutput("free_count", int'(free_count), e.freeSlots);
      end
    end
  end

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_grant"}, int'(grant), 0);
    checkOutput({tag, "_deny"}, int'(deny), 0);
    checkOutput({tag, "_locked"}, int'(locked), 0);
    checkOutput({tag, "_busy"}, int'(busy), 0);
    checkOutput({tag, "_alloc_slot"}, int'(alloc_slot), 0);
    checkOutput({tag, "_occupied"}, int'(occupied), 0);
    checkOutput({tag, "_free_count"}, int'(free_count), SLOTS);
    checkOutput({tag, "_entry_time_out"}, int'(entry_time_out), 0);
    checkOutput({tag, "_duration_out"}, int'(duration_out), 0);
  endtask

  // Lockout must last exactly LOCK_CYCLES cycles and ignore every input.
  task automatic waitLockout();
    int n = 0;
    request = 1'b1;
    exit_req = 1'b1;
    confirm = 1'b1;
    slot_id = '0;
    for (int i = 0; i < LOCK_CYCLES + 10; i++) begin
      @(negedge clock);
      if (i == 0) checkOutput("busy_lockout", int'(busy), 1);
      if (i == 3) begin
        request = 1'b0;
        exit_req = 1'b0;
        confirm = 1'b0;
      end
      if (locked) n++;
      else break;
    end
    request = 1'b0;
    exit_req = 1'b0;
    confirm = 1'b0;
    checkOutput("lock_cycles", n, LOCK_CYCLES);
    tick();
  endtask

  // One IDLE-started transaction: predict the outcome, drive it, then check the bus is idle again.
  task automatic applyStimulus(input bit req, input bit ex, input int sid,
                               input int sTok, input int uTok, input int t);
    bit toWait = 0;
    bit isExit = 0;
    bit lockExp = 0;
    int s;
    request = req;
    exit_req = ex;
    slot_id = IDX_W'(sid);
    if (ex) begin
      if (occModel[sid]) begin
        toWait = 1;
        isExit = 1;
      end else pushResult(1'b0);
    end else if (req) begin
      if (modelFree() == 0) pushResult(1'b0);
      else toWait = 1;
    end
    tick();
    request = 1'b0;
    exit_req = 1'b0;
    if (toWait) begin
      checkOutput("busy_wait", int'(busy), 1);
      confirm = 1'b1;
      system_token = TOKEN_W'(sTok);
      user_token = TOKEN_W'(uTok);
      time_data = TIME_W'(t);
      if (sTok == uTok) begin
        failModel = 0;
        if (isExit) begin
          lastSlot = sid;
          lastEntry = entryModel[sid];
          lastDuration = (t - entryModel[sid] + 256) % 256;
          occModel[sid] = 1'b0;
        end else begin
          s = -1;
          for (int i = 0; i < SLOTS; i++) if (s < 0 && !occModel[i]) s = i;
          occModel[s] = 1'b1;
          entryModel[s] = t;
          lastSlot = s;
          lastEntry = t;
          lastDuration = 0;
        end
        pushResult(1'b1);
      end else begin
        failModel++;
        if (failModel == MAX_TRIES) begin
          failModel = 0;
          lockExp = 1;
        end
        pushResult(1'b0);
      end
      tick();
      confirm = 1'b0;
    end
    if (lockExp) waitLockout();
    else begin
      tick();
      checkOutput("locked_idle", int'(locked), 0);
      checkOutput("busy_idle", int'(busy), 0);
    end
    checkOutput("pending", expQ.size(), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sTok, uTok, op;
    modelReset();
    repeat (3) @(posedge clock);
    #1;
    checkResetState("reset");
    @(negedge clock);
    reset = 1'b1;
    tick();

    // Fill all bays, then overflow.
    applyStimulus(1, 0, 0, 5, 5, 10);
    applyStimulus(1, 0, 0, 5, 5, 20);
    applyStimulus(1, 0, 0, 5, 5, 30);
    applyStimulus(1, 0, 0, 5, 5, 40);
    checkOutput("full_occupied", int'(occupied), 15);
    checkOutput("full_free_count", int'(free_count), 0);
    applyStimulus(1, 0, 0, 5, 5, 50);

    // Re-park bay 2 late in the time window, exit after the clock wraps (250 -> 4).
    applyStimulus(0, 1, 2, 5, 5, 35);
    applyStimulus(1, 0, 0, 5, 5, 250);
    applyStimulus(0, 1, 2, 5, 5, 4);
    checkOutput("wrap_duration", int'(duration_out), 10);

    // Exit from an empty bay.
    applyStimulus(0, 1, 2, 5, 5, 60);

    // Three wrong tokens lock out; a correct transaction works afterwards.
    applyStimulus(1, 0, 0, 5, 1, 70);
    applyStimulus(1, 0, 0, 5, 1, 71);
    applyStimulus(1, 0, 0, 5, 1, 72);
    applyStimulus(1, 0, 0, 5, 5, 80);

    // A match between failures clears the count.
    applyStimulus(0, 1, 0, 5, 1, 85);
    applyStimulus(0, 1, 0, 5, 1, 86);
    applyStimulus(0, 1, 0, 5, 5, 90);
    applyStimulus(0, 1, 1, 5, 1, 91);
    applyStimulus(0, 1, 1, 5, 1, 92);

    // Exit wins over a simultaneous entry request.
    applyStimulus(1, 1, 1, 5, 5, 100);

    // Asynchronous reset in the middle of a transaction.
    request = 1'b1;
    tick();
    request = 1'b0;
    checkOutput("busy_before_reset", int'(busy), 1);
    #2;
    reset = 1'b0;
    #1;
    checkResetState("mid_reset");
    modelReset();
    @(negedge clock);
    reset = 1'b1;
    tick();

`ifdef CONFIRM_TIMEOUT_EN
    request = 1'b1;
    tick();
    request = 1'b0;
    pushResult(1'b0);
    repeat (TIMEOUT + 3) tick();
    checkOutput("timeout_pending", expQ.size(), 0);
    checkOutput("timeout_busy", int'(busy), 0);
`endif

    for (int n = 0; n < 200; n++) begin
      sTok = int'($urandom_range(0, 7));
      uTok = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : sTok;
      op = int'($urandom_range(0, 8));
      if (op < 4) applyStimulus(1, 0, 0, sTok, uTok, int'($urandom_range(0, 255)));
      else if (op < 8) applyStimulus(0, 1, int'($urandom_range(0, SLOTS - 1)), sTok, uTok,
                                     int'($urandom_range(0, 255)));
      else applyStimulus(1, 1, int'($urandom_range(0, SLOTS - 1)), sTok, uTok,
                         int'($urandom_range(0, 255)));
    end

    repeat (3) tick();
    checkOutput("final_pending", expQ.size(), 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
